// File: rtl/matmul_apb_pkg.sv
// Shared types and defaults for the matmul APB slave front-end.
package matmul_apb_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_BUS_WIDTH   = 64;
  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_DEC_BITS    = 5;
  localparam int unsigned DEF_TIMEOUT_CYC = 16;

  localparam logic [DEF_DEC_BITS-1:0] DEF_FLAGS_OFF = 5'h0C;
  localparam logic [DEF_DEC_BITS-1:0] DEF_SP_OFF    = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Read-timeout counter: cleared by load, counts while enabled, flags the last allowed cycle.
module apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expire_c = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_matmul_slave_gen2.sv
// APB slave front-end of the matmul operand/flag memory with byte strobes,
// handshaked reads and address protection. Define APB_SLV_TIMEOUT_EN for a read timeout.
module apb_matmul_slave_gen2
  import matmul_apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DEC_BITS    = DEF_DEC_BITS,
  parameter logic [DEC_BITS-1:0] FLAGS_OFF = DEF_FLAGS_OFF,
  parameter logic [DEC_BITS-1:0] SP_OFF    = DEF_SP_OFF,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [STRB_WIDTH-1:0] pstrb_i,
  input  logic                  start_bit_i,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BUS_WIDTH-1:0]  mem_wdata_o,
  output logic [STRB_WIDTH-1:0] mem_wstrb_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
  input  logic                  mem_rvalid_i
);

  if ((BUS_WIDTH % 8 != 0) || (DATA_WIDTH > BUS_WIDTH) || (DEC_BITS > ADDR_WIDTH) ||
      (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("apb_matmul_slave_gen2: inconsistent parameters");
  end

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0]  wdata_q;
  logic [BUS_WIDTH-1:0]  rdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  err_q;

  logic setup_c;
  logic err_setup_c;
  logic wr_go_c;
  logic rd_req_c;
  logic timeout_c;

  assign setup_c  = psel_i & ~penable_i;
  assign wr_go_c  = (state_q == ST_WR) & ~err_q;
  assign rd_req_c = (state_q == ST_RD_WAIT) & ~err_q;

  // Protection decode evaluated on the setup phase
  always_comb begin
    err_setup_c = start_bit_i;
    if (pwrite_i) begin
      err_setup_c = start_bit_i | (paddr_i[DEC_BITS-1:0] == FLAGS_OFF) |
                    (paddr_i[DEC_BITS-1:0] >= SP_OFF);
    end else begin
      err_setup_c = start_bit_i | (pstrb_i != '0);
    end
  end

`ifdef APB_SLV_TIMEOUT_EN
  apb_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (state_q == ST_IDLE),
    .en_i     (rd_req_c & ~mem_rvalid_i),
    .expire_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping psel outside IDLE aborts the transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup_c) begin
          state_d = pwrite_i ? ST_WR : ST_RD_WAIT;
        end
      end
      ST_WR: begin
        state_d = psel_i ? ST_DONE : ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if (err_q || mem_rvalid_i || timeout_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!psel_i || penable_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer context captured at setup; read data and timeout error land here later
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if ((state_q == ST_IDLE) && setup_c) begin
      addr_q  <= paddr_i;
      wdata_q <= pwdata_i;
      strb_q  <= pstrb_i;
      rdata_q <= '0;
      err_q   <= err_setup_c;
    end else if (rd_req_c && mem_rvalid_i) begin
      rdata_q <= mem_rdata_i;
    end else if (rd_req_c && timeout_c) begin
      err_q   <= 1'b1;
    end
  end

  always_comb begin
    pready_o    = 1'b0;
    pslverr_o   = 1'b0;
    prdata_o    = '0;
    busy_o      = (state_q != ST_IDLE);
    mem_we_o    = wr_go_c;
    mem_re_o    = rd_req_c;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (wr_go_c || rd_req_c) begin
      mem_addr_o = addr_q;
    end
    if (wr_go_c) begin
      mem_wdata_o = wdata_q;
      mem_wstrb_o = strb_q;
    end
    if (state_q == ST_DONE) begin
      pready_o  = 1'b1;
      pslverr_o = err_q;
      prdata_o  = rdata_q;
    end
  end

endmodule

// File: tb/tb_apb_matmul_slave_gen2.sv
// Directed bench for apb_matmul_slave_gen2: writes, handshaked reads, protection errors, aborts, timeout.
module tb_apb_matmul_slave_gen2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        psel_i, penable_i, pwrite_i, start_bit_i;
  logic [31:0] paddr_i;
  logic [63:0] pwdata_i;
  logic [7:0]  pstrb_i;
  logic        pready_o, pslverr_o, busy_o;
  logic [63:0] prdata_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_we_o, mem_re_o;
  logic [63:0] mem_rdata_i;
  logic        mem_rvalid_i;

  int n_checks = 0;
  int n_fail   = 0;

  apb_matmul_slave_gen2 dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .psel_i       (psel_i),
    .penable_i    (penable_i),
    .pwrite_i     (pwrite_i),
    .paddr_i      (paddr_i),
    .pwdata_i     (pwdata_i),
    .pstrb_i      (pstrb_i),
    .start_bit_i  (start_bit_i),
    .pready_o     (pready_o),
    .pslverr_o    (pslverr_o),
    .prdata_o     (prdata_o),
    .busy_o       (busy_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_we_o     (mem_we_o),
    .mem_re_o     (mem_re_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apb_setup(input logic [31:0] a, input logic wr, input logic [63:0] d,
                           input logic [7:0] s, input logic sb);
    cyc();
    psel_i      = 1'b1;
    penable_i   = 1'b0;
    pwrite_i    = wr;
    paddr_i     = a;
    pwdata_i    = d;
    pstrb_i     = s;
    start_bit_i = sb;
  endtask

  // Setup, one wait state with the write strobe, then DONE; start_bit flips after setup.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic sb, input logic exp_err);
    apb_setup(a, 1'b1, d, s, sb);
    cyc();
    penable_i   = 1'b1;
    start_bit_i = ~sb;
    @(negedge clk_i);
    check({tag, "_we"}, mem_we_o, !exp_err);
    check({tag, "_wait_pready"}, pready_o, 1'b0);
    if (!exp_err) begin
      check({tag, "_addr"}, mem_addr_o, a);
      check({tag, "_wstrb"}, mem_wstrb_o, s);
      check({tag, "_wdata"}, mem_wdata_o, d);
    end
    cyc();
    @(negedge clk_i);
    check({tag, "_pready"}, pready_o, 1'b1);
    check({tag, "_pslverr"}, pslverr_o, exp_err);
    check({tag, "_we_done"}, mem_we_o, 1'b0);
  endtask

  // Memory answers dly cycles after mem_re_o first rises.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [7:0] s,
                         input logic sb, input int dly, input logic [63:0] rd,
                         input logic exp_err);
    apb_setup(a, 1'b0, 64'h0, s, sb);
    cyc();
    penable_i   = 1'b1;
    start_bit_i = 1'b0;
    if (exp_err) begin
      @(negedge clk_i);
      check({tag, "_re"}, mem_re_o, 1'b0);
      check({tag, "_wait_pready"}, pready_o, 1'b0);
      cyc();
    end else begin
      for (int i = 0; i <= dly; i++) begin
        if (i == dly) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rd;
        end
        @(negedge clk_i);
        check({tag, "_re"}, mem_re_o, 1'b1);
        check({tag, "_wait_pready"}, pready_o, 1'b0);
        cyc();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 64'h0;
      end
    end
    @(negedge clk_i);
    check({tag, "_pready"}, pready_o, 1'b1);
    check({tag, "_pslverr"}, pslverr_o, exp_err);
    check({tag, "_prdata"}, prdata_o, exp_err ? 64'h0 : rd);
    check({tag, "_re_done"}, mem_re_o, 1'b0);
  endtask

  task automatic go_idle();
    cyc();
    psel_i    = 1'b0;
    penable_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_i        = 1'b1;
    psel_i       = 1'b0;
    penable_i    = 1'b0;
    pwrite_i     = 1'b0;
    paddr_i      = 32'h0;
    pwdata_i     = 64'h0;
    pstrb_i      = 8'h0;
    start_bit_i  = 1'b0;
    mem_rdata_i  = 64'h0;
    mem_rvalid_i = 1'b0;

    repeat (2) @(negedge clk_i);
    check("rst_pready", pready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_re", mem_re_o, 1'b0);
    check("rst_prdata", prdata_o, 64'h0);
    cyc();
    rst_i = 1'b0;

    // Plain write, then back-to-back traffic without idle gaps
    do_write("wr04", 32'h04, 64'h1122334455667788, 8'h0F, 1'b0, 1'b0);
    do_read("rd08", 32'h08, 8'h00, 1'b0, 3, 64'hDEADBEEFCAFEF00D, 1'b0);
    do_read("rd_same_cyc", 32'h20, 8'h00, 1'b0, 0, 64'h0123456789ABCDEF, 1'b0);
    do_write("wr_flags", 32'h0C, 64'hAAAA, 8'hFF, 1'b0, 1'b1);
    do_write("wr_sp", 32'h14, 64'hBBBB, 8'hFF, 1'b0, 1'b1);
    do_write("wr_0f", 32'h0F, 64'h5A5A, 8'hF0, 1'b0, 1'b0);
    do_write("wr_wrap", 32'h2C, 64'hCCCC, 8'h01, 1'b0, 1'b1);
    do_write("wr_start", 32'h00, 64'hDDDD, 8'hFF, 1'b1, 1'b1);
    do_write("wr_start_late", 32'h00, 64'hEEEE, 8'h3C, 1'b0, 1'b0);
    do_read("rd_strb", 32'h08, 8'h01, 1'b0, 0, 64'h0, 1'b1);
    do_read("rd_start", 32'h08, 8'h00, 1'b1, 0, 64'h0, 1'b1);
    do_read("rd_flags", 32'h0C, 8'h00, 1'b0, 1, 64'h00000000000000A5, 1'b0);
    go_idle();
    @(negedge clk_i);
    check("idle_busy", busy_o, 1'b0);

    // Abort in RD_WAIT, then a late rvalid must be ignored
    apb_setup(32'h08, 1'b0, 64'h0, 8'h00, 1'b0);
    cyc();
    penable_i = 1'b1;
    @(negedge clk_i);
    check("abort_re_on", mem_re_o, 1'b1);
    go_idle();
    @(negedge clk_i);
    check("abort_re_still", mem_re_o, 1'b1);
    cyc();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'hBAD0BAD0BAD0BAD0;
    @(negedge clk_i);
    check("abort_re_off", mem_re_o, 1'b0);
    check("abort_busy", busy_o, 1'b0);
    check("abort_pready", pready_o, 1'b0);
    cyc();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 64'h0;
    @(negedge clk_i);
    check("late_rvalid_pready", pready_o, 1'b0);
    check("late_rvalid_busy", busy_o, 1'b0);

    // Asynchronous reset during WR kills the write strobe at once
    apb_setup(32'h04, 1'b1, 64'h77, 8'hFF, 1'b0);
    cyc();
    penable_i = 1'b1;
    @(negedge clk_i);
    check("rstwr_we_on", mem_we_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rstwr_we_off", mem_we_o, 1'b0);
    check("rstwr_busy", busy_o, 1'b0);
    psel_i    = 1'b0;
    penable_i = 1'b0;
    cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rstwr_pready", pready_o, 1'b0);

    // Memory never answers
    apb_setup(32'h08, 1'b0, 64'h0, 8'h00, 1'b0);
    cyc();
    penable_i = 1'b1;
    n = 0;
`ifdef APB_SLV_TIMEOUT_EN
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (pready_o) break;
      if (mem_re_o) n++;
      cyc();
    end
    check("tmo_re_cycles", 64'(n), 64'd16);
    check("tmo_pready", pready_o, 1'b1);
    check("tmo_pslverr", pslverr_o, 1'b1);
    check("tmo_prdata", prdata_o, 64'h0);
    check("tmo_re_off", mem_re_o, 1'b0);
    go_idle();
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (mem_re_o && !pready_o) n++;
      cyc();
    end
    check("wait_re_cycles", 64'(n), 64'd100);
    @(negedge clk_i);
    check("wait_busy", busy_o, 1'b1);
    check("wait_re", mem_re_o, 1'b1);
    check("wait_pready", pready_o, 1'b0);
    go_idle();
    cyc();
`endif
    @(negedge clk_i);
    check("final_busy", busy_o, 1'b0);

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
